pipe_collide_score: RTL
=======================

Name: pipe_collide_score

Overview:
- Game-logic stage directly downstream of the pipe generator.
- Consumes both pipes' positions and the bird's vertical position, and detects collisions with pipes, floor and ceiling.
- Counts pipes cleared as a 3-digit BCD score.
- Drives the Lost flag that the pipe generator and the bird-physics block consume.

Parameters:
- SCREEN_W, 800: horizontal pixels; a pipe with X >= SCREEN_W is off-screen and inert.
- FLOOR_Y, 480: first pixel row of the floor.
- BIRD_X, 200: fixed left edge of the bird.
- BIRD_W, 34: bird width in pixels.
- BIRD_H, 24: bird height in pixels.
- PIPE_W, 52: pipe width in pixels.
- GAP_H, 120: vertical opening of each pipe; PipePosY is the top row of the opening.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- Start  in  1  start/restart request, single-cycle pulse or level
- BirdPosY  in  10  top row of the bird
- PipePosX1  in  10  left edge of pipe 1
- PipePosY1  in  10  gap top of pipe 1
- PipePosX2  in  10  left edge of pipe 2
- PipePosY2  in  10  gap top of pipe 2
- Lost  out  1  high while in LOST state
- Playing  out  1  high while in PLAY state
- Score  out  12  BCD hundreds:tens:units
- ScoreTick  out  1  one-cycle pulse for each increment event

Behaviour:
- Reset (Reset_n low, asynchronous): state=IDLE; Lost=0, Playing=0, Score=0, ScoreTick=0; pass flags P1/P2 cleared.
- Arithmetic: all edge sums are computed at 11 bits (e.g. PipePosX+PIPE_W, BirdPosY+BIRD_H) so that X values up to 1023 do not wrap.
- Horizontal overlap for pipe k, active only when PipePosXk < SCREEN_W: (PipePosXk < BIRD_X+BIRD_W) and (PipePosXk+PIPE_W > BIRD_X).
- Pipe hit for pipe k: overlap, and either BirdPosY < PipePosYk or BirdPosY+BIRD_H > PipePosYk+GAP_H.
- Boundary hit: BirdPosY+BIRD_H >= FLOOR_Y, or BirdPosY == 0.
- Collision is the OR of pipe hit 1, pipe hit 2 and boundary hit, evaluated combinationally from the current inputs.
- Pass event for pipe k: P_k==0 and PipePosXk+PIPE_W < BIRD_X. On a pass event, P_k is set.
- P_k is cleared when PipePosXk >= BIRD_X+BIRD_W. This covers the generator respawning the pipe at X >= 800.
- State machine:
  - IDLE: Playing=0, Lost=0. Start -> PLAY; on the same edge Score=0 and P1/P2 are cleared.
  - PLAY: Playing=1.
    - If collision: -> LOST on the next edge; the score is NOT incremented in that cycle (collision has priority over a pass).
    - Otherwise, each pass event adds 1. Two pass events in the same cycle add 2. ScoreTick pulses for one cycle when the increment is nonzero.
    - Start is ignored.
  - LOST: Lost=1, Playing=0, Score frozen. Start -> IDLE. Score is held until the next IDLE->PLAY transition.
  - Unreachable state encodings -> IDLE.
- Latency: registered outputs.
  - An input condition on cycle n is reflected on Lost/Score/ScoreTick at cycle n+1.
  - Lost is asserted exactly one clock after the first colliding sample.
- Score is BCD with per-digit carry. It saturates at 999; ScoreTick is still asserted on a saturated increment.
- Reset mid-game forces IDLE immediately, without waiting for a clock edge.

Optional Feature:
- Macro: PIPE_COLLIDE_HISCORE_EN.
- When defined:
  - Adds output HiScore [11:0] (BCD), reset to 0.
  - On the PLAY->LOST edge, if Score > HiScore, HiScore <= Score (compared as BCD digits, most significant first).
  - HiScore is cleared only by reset.
- When undefined: no HiScore port and no comparator logic; all other behaviour is unchanged.

Test Plan:
1. Reset low, then release; pulse Start with BirdPosY=200 and both pipes at X=800 -> Playing=1 next cycle; Score=0; Lost=0 for 1000 cycles.
2. PLAY, PipePosX1 stepped from 300 down to 100 with BirdPosY inside the gap (PipePosY1=150, BirdPosY=180) -> Score=0x001 and a single ScoreTick when X1+52 crosses below 200; no further increment while X1 keeps decreasing; the flag re-arms after X1 is set to 1000.
3. PLAY, PipePosX1=190, PipePosY1=250, BirdPosY=200 -> Lost=1 exactly one cycle later and Playing=0; Score frozen; Start -> IDLE, a second Start -> PLAY with Score=0.
4. PLAY, BirdPosY=460 (460+24 >= 480) -> Lost=1 next cycle; repeat with BirdPosY=0 -> Lost=1.
5. Preload Score to 0x099 and produce both pass events in one cycle -> Score=0x101 with one ScoreTick; at 0x999 a further pass keeps 0x999; a pass coinciding with a collision -> no increment, Lost=1.
6. Reset_n asserted mid-PLAY between clock edges -> all outputs reach their reset values immediately, without waiting for a clock edge. With PIPE_COLLIDE_HISCORE_EN defined: end games with scores 5, then 3 -> HiScore=0x005.

Source files
------------

// File: rtl/pipe_collide_score.sv
// pipe_collide_score: collision detection, BCD pass scoring and game state for the pipe game.
// Optional high-score register enabled by `define PIPE_COLLIDE_HISCORE_EN. Rev 1.0
`default_nettype none

module pipe_collide_score #(
  parameter int SCREEN_W = 800,
  parameter int FLOOR_Y  = 480,
  parameter int BIRD_X   = 200,
  parameter int BIRD_W   = 34,
  parameter int BIRD_H   = 24,
  parameter int PIPE_W   = 52,
  parameter int GAP_H    = 120
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [9:0]  BirdPosY,
  input  logic [9:0]  PipePosX1,
  input  logic [9:0]  PipePosY1,
  input  logic [9:0]  PipePosX2,
  input  logic [9:0]  PipePosY2,
  output logic        Lost,
  output logic        Playing,
  output logic [11:0] Score,
`ifdef PIPE_COLLIDE_HISCORE_EN
  output logic [11:0] HiScore,
`endif
  output logic        ScoreTick
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_LOST = 2'd2;

  localparam logic [10:0] BIRD_LEFT  = 11'(BIRD_X);
  localparam logic [10:0] BIRD_RIGHT = 11'(BIRD_X + BIRD_W);

  logic [1:0]  state_q, state_d;
  logic [11:0] score_q, score_d;
  logic        tick_q, tick_d;
  logic        p1_q, p1_d, p2_q, p2_d;
`ifdef PIPE_COLLIDE_HISCORE_EN
  logic [11:0] hi_q, hi_d;
`endif

  logic [10:0] bird_top, bird_bot;
  logic [10:0] x1, x2, x1_end, x2_end;
  logic        hit1, hit2, hit_bound, collision;
  logic        pass1, pass2, clr1, clr2;

  // Saturating BCD increment with per-digit carry.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v != 12'h999) begin
      if (v[3:0] != 4'd9) begin
        r[3:0] = v[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (v[7:4] != 4'd9) begin
          r[7:4] = v[7:4] + 4'd1;
        end else begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  // Pipe k is a hit when it overlaps the bird horizontally and the bird leaves its gap.
  function automatic logic pipe_hit(input logic [10:0] x, input logic [10:0] x_end,
                                    input logic [9:0] gap_top, input logic [10:0] b_top,
                                    input logic [10:0] b_bot);
    logic overlap;
    overlap = (x < 11'(SCREEN_W)) && (x < BIRD_RIGHT) && (x_end > BIRD_LEFT);
    return overlap && ((b_top < {1'b0, gap_top}) || (b_bot > ({1'b0, gap_top} + 11'(GAP_H))));
  endfunction

  always_comb begin
    bird_top  = {1'b0, BirdPosY};
    bird_bot  = bird_top + 11'(BIRD_H);
    x1        = {1'b0, PipePosX1};
    x2        = {1'b0, PipePosX2};
    x1_end    = x1 + 11'(PIPE_W);
    x2_end    = x2 + 11'(PIPE_W);
    hit1      = pipe_hit(x1, x1_end, PipePosY1, bird_top, bird_bot);
    hit2      = pipe_hit(x2, x2_end, PipePosY2, bird_top, bird_bot);
    hit_bound = (bird_bot >= 11'(FLOOR_Y)) || (BirdPosY == 10'd0);
    collision = hit1 || hit2 || hit_bound;
    pass1     = !p1_q && (x1_end < BIRD_LEFT);
    pass2     = !p2_q && (x2_end < BIRD_LEFT);
    clr1      = x1 >= BIRD_RIGHT;
    clr2      = x2 >= BIRD_RIGHT;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      score_q <= 12'h000;
      tick_q  <= 1'b0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
`ifdef PIPE_COLLIDE_HISCORE_EN
      hi_q    <= 12'h000;
`endif
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      tick_q  <= tick_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
`ifdef PIPE_COLLIDE_HISCORE_EN
      hi_q    <= hi_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start)     state_d = S_PLAY;
      S_PLAY:  if (collision) state_d = S_LOST;
      S_LOST:  if (Start)     state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    score_d = score_q;
    tick_d  = 1'b0;
    p1_d    = p1_q;
    p2_d    = p2_q;
`ifdef PIPE_COLLIDE_HISCORE_EN
    hi_d    = hi_q;
`endif
    if (state_q == S_IDLE && Start) begin
      score_d = 12'h000;
      p1_d    = 1'b0;
      p2_d    = 1'b0;
    end else if (state_q == S_PLAY) begin
      p1_d = clr1 ? 1'b0 : (pass1 ? 1'b1 : p1_q);
      p2_d = clr2 ? 1'b0 : (pass2 ? 1'b1 : p2_q);
      // A collision outranks any pass in the same cycle.
      if (!collision) begin
        if (pass1) score_d = bcd_inc(score_d);
        if (pass2) score_d = bcd_inc(score_d);
        tick_d = pass1 || pass2;
      end
`ifdef PIPE_COLLIDE_HISCORE_EN
      // Plain unsigned compare of packed BCD orders digits most significant first.
      else if (score_q > hi_q) begin
        hi_d = score_q;
      end
`endif
    end
  end

  always_comb begin
    Lost      = (state_q == S_LOST);
    Playing   = (state_q == S_PLAY);
    Score     = score_q;
    ScoreTick = tick_q;
`ifdef PIPE_COLLIDE_HISCORE_EN
    HiScore   = hi_q;
`endif
  end

endmodule

`default_nettype wire
